bin_power_accumulator: RTL and testbench
========================================

Name: bin_power_accumulator

Overview:
- Sits directly downstream of the FFT bin counter.
- Takes each valid FFT sample (re/im) tagged with the counter's bin_num and squares it into power.
- Integrates power per bin over NUM_FRAMES FFT frames in on-chip RAM.
- Then streams the integrated spectrum out over a valid/ready interface, clearing each bin as it is read.

Parameters:
- NUM_BINS, 1024, FFT bins per frame; power of two, ≥4.
- DATA_W, 16, signed width of fft_re/fft_im.
- ACC_W, 48, accumulator width; must be ≥ 2*DATA_W+1.
- NUM_FRAMES, 16, frames integrated per output spectrum; ≥1.
- BIN_W, 32, width of bin_num/out_bin.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fft_valid  in  1  sample qualifier.
- bin_num  in  BIN_W  bin index of current sample, from the bin counter.
- fft_re  in  DATA_W  signed real part.
- fft_im  in  DATA_W  signed imaginary part.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_bin  out  BIN_W  bin index of output beat.
- out_data  out  ACC_W  integrated power, unsigned.
- out_last  out  1  high on beat for bin NUM_BINS-1.
- drop_pulse  out  1  one-cycle pulse per fft_valid sample discarded.
- sat_flag  out  1  sticky: some bin saturated during current integration; cleared at start of next integration.

Behaviour:
- Reset values:
  - out_valid=0, out_bin=0, out_data=0, out_last=0, drop_pulse=0, sat_flag=0.
  - State=CLEAR; frame count=0.
- Power is the unsigned (2*DATA_W+1)-bit value re*re + im*im, zero-extended to ACC_W. re=im=-2^(DATA_W-1) gives 2^(2*DATA_W-1) exactly, with no overflow.
- Accumulation is saturating at 2^ACC_W-1. Any saturation sets sat_flag.
- State CLEAR:
  - Writes 0 to all NUM_BINS RAM words, one per cycle (NUM_BINS cycles).
  - Then goes to ACCUM.
  - fft_valid samples in CLEAR are dropped and pulse drop_pulse.
- State ACCUM, 3-stage read-modify-write pipeline:
  - S0: register bin/re/im; issue RAM read.
  - S1: products computed; RAM data returns.
  - S2: add and write back.
  - Accepts one sample per cycle, no backpressure.
  - Hazard: the same bin presented in back-to-back or 2-apart cycles must forward the in-flight sum; no lost updates.
  - bin_num ≥ NUM_BINS: sample dropped, drop_pulse=1, no RAM write.
  - A frame ends when a sample with bin_num==NUM_BINS-1 is accepted, which increments the frame count.
  - After frame NUM_FRAMES ends: stop accepting, wait for the pipeline to drain (2 cycles), then go to DUMP.
- State DUMP:
  - Streams bins 0..NUM_BINS-1 in order.
  - Each RAM word is written to 0 in the cycle its read is issued.
  - Output register is AXI-stream style: while out_valid=1 && out_ready=0, out_bin/out_data/out_last are held stable.
  - out_valid is never dropped without a handshake.
  - Sustains one beat per cycle with out_ready held high. First out_valid comes no later than 2 cycles after entering DUMP.
  - After the out_last handshake: frame count=0, sat_flag cleared, return to ACCUM.
  - fft_valid during DUMP or the drain: dropped, drop_pulse=1.
- Simultaneous events:
  - A final-bin sample accepted in the same cycle the count hits NUM_FRAMES is still accumulated.
  - out_ready toggling every cycle produces no duplicated or skipped bins.
- Reset mid-operation (any state): outputs return to reset values the next cycle, and the FSM re-enters CLEAR. Partial sums are discarded.

Test Plan (NUM_BINS=8, NUM_FRAMES=2, DATA_W=16, ACC_W=48):
- Reset, wait CLEAR; 2 frames of bins 0..7 with re=bin, im=0, out_ready=1 -> 8 beats, out_data=2*bin², out_last only on bin 7, drop_pulse never.
- re=im=-32768 on every sample, 2 frames -> each out_data=2*2^31=4294967296; sat_flag=0.
- Same bin 3 presented 4 consecutive cycles with re=1, im=1, then bins 0..7 twice (re=im=0) -> out_data[3]=8, all others 0.
- During DUMP hold out_ready=0 for 5 cycles, then random toggling -> out_valid stays 1, data stable while stalled, bins 0..7 each exactly once; samples sent meanwhile pulse drop_pulse and do not appear in the next spectrum.
- bin_num=9 with re=100 -> drop_pulse=1 for that cycle, all bins unaffected.
- Assert reset mid-ACCUM after 5 samples, then run 2 clean frames of re=1, im=0 -> every out_data=2 (no residue); ACC_W=33 variant with max inputs -> out_data=2^33-1, sat_flag=1.

Source files
------------

// File: rtl/bin_power_accumulator.sv
// Per-bin power integrator: squares FFT samples, accumulates them per bin over
// NUM_FRAMES frames in on-chip RAM, then streams and clears the spectrum.
module bin_power_accumulator #(
    parameter int NUM_BINS   = 1024,
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 48,
    parameter int NUM_FRAMES = 16,
    parameter int BIN_W      = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fft_valid,
    input  logic [BIN_W-1:0]         bin_num,
    input  logic signed [DATA_W-1:0] fft_re,
    input  logic signed [DATA_W-1:0] fft_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BIN_W-1:0]         out_bin,
    output logic [ACC_W-1:0]         out_data,
    output logic                     out_last,
    output logic                     drop_pulse,
    output logic                     sat_flag
);

    localparam int ADDR_W = $clog2(NUM_BINS);
    localparam int POW_W  = 2 * DATA_W + 1;
    localparam int FCNT_W = $clog2(NUM_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Integration RAM and its registered read port
    logic [ACC_W-1:0]  r_mem [NUM_BINS];
    logic [ACC_W-1:0]  r_ram_q;

    // Control counters
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_drain_cnt;
    logic [FCNT_W-1:0] r_frame_cnt;

    // Read-modify-write pipeline
    logic                     r_s1_valid;
    logic [ADDR_W-1:0]        r_s1_addr;
    logic signed [DATA_W-1:0] r_s1_re;
    logic signed [DATA_W-1:0] r_s1_im;
    logic                     r_s2_valid;
    logic [ADDR_W-1:0]        r_s2_addr;
    logic [ACC_W-1:0]         r_s2_pow;
    logic [ACC_W-1:0]         r_s2_old;
    logic                     r_wb_valid;
    logic [ADDR_W-1:0]        r_wb_addr;
    logic [ACC_W-1:0]         r_wb_data;

    // Dump path
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_more;
    logic              r_dq_valid;
    logic [ADDR_W-1:0] r_dq_addr;
    logic              r_out_valid;
    logic [BIN_W-1:0]  r_out_bin;
    logic [ACC_W-1:0]  r_out_data;
    logic              r_out_last;
    logic              r_drop;
    logic              r_sat;

    // Combinational helpers
    logic                       w_in_range;
    logic                       w_accept;
    logic                       w_last_bin_acc;
    logic                       w_frames_done;
    logic                       w_clr_done;
    logic                       w_drain_done;
    logic                       w_dump_done;
    logic signed [2*DATA_W-1:0] w_re_sq;
    logic signed [2*DATA_W-1:0] w_im_sq;
    logic [POW_W-1:0]           w_pow;
    logic [ACC_W-1:0]           w_old_s1;
    logic [ACC_W:0]             w_sum_ext;
    logic                       w_sat;
    logic [ACC_W-1:0]           w_sum;
    logic                       w_out_load;
    logic                       w_rd_issue;
    logic                       w_we;
    logic [ADDR_W-1:0]          w_waddr;
    logic [ACC_W-1:0]           w_wdata;
    logic                       w_re_en;
    logic [ADDR_W-1:0]          w_raddr;

    assign w_in_range     = (bin_num < BIN_W'(NUM_BINS));
    assign w_accept       = (r_state == ST_ACCUM) && fft_valid && w_in_range;
    assign w_last_bin_acc = w_accept && (bin_num == BIN_W'(NUM_BINS - 1));
    assign w_frames_done  = w_last_bin_acc && (r_frame_cnt == FCNT_W'(NUM_FRAMES - 1));
    assign w_clr_done     = (r_state == ST_CLEAR) && (r_clr_addr == ADDR_W'(NUM_BINS - 1));
    assign w_drain_done   = (r_state == ST_DRAIN) && r_drain_cnt;
    assign w_dump_done    = (r_state == ST_DUMP) && r_out_valid && r_out_last && out_ready;

    // S1 power: both squares are non-negative, so their sum is exact in POW_W bits
    assign w_re_sq = r_s1_re * r_s1_re;
    assign w_im_sq = r_s1_im * r_s1_im;
    assign w_pow   = {1'b0, w_re_sq} + {1'b0, w_im_sq};

    // S2 saturating add
    assign w_sum_ext = {1'b0, r_s2_old} + {1'b0, r_s2_pow};
    assign w_sat     = w_sum_ext[ACC_W];
    assign w_sum     = w_sat ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];

    // Dump flow: output register refills from the RAM stage when free or accepted
    assign w_out_load = r_dq_valid && (!r_out_valid || out_ready);
    assign w_rd_issue = (r_state == ST_DUMP) && r_rd_more && (!r_dq_valid || w_out_load);

    // Select the freshest value of the S1 bin: sum in S2 now, else last write, else RAM
    always_comb begin
        w_old_s1 = r_ram_q;
        if (r_s2_valid && (r_s2_addr == r_s1_addr)) begin
            w_old_s1 = w_sum;
        end else if (r_wb_valid && (r_wb_addr == r_s1_addr)) begin
            w_old_s1 = r_wb_data;
        end else begin
            w_old_s1 = r_ram_q;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (w_clr_done) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_ACCUM: begin
                if (w_frames_done) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = ST_DUMP;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DUMP: begin
                if (w_dump_done) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_DUMP;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    // RAM port muxing: clear sweep, accumulate write-back, or clear-on-read in dump
    always_comb begin
        w_we    = 1'b0;
        w_waddr = {ADDR_W{1'b0}};
        w_wdata = {ACC_W{1'b0}};
        w_re_en = 1'b0;
        w_raddr = {ADDR_W{1'b0}};
        case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
            end
            ST_DUMP: begin
                w_we    = w_rd_issue;
                w_waddr = r_rd_addr;
                w_re_en = w_rd_issue;
                w_raddr = r_rd_addr;
            end
            ST_ACCUM: begin
                w_we    = r_s2_valid;
                w_waddr = r_s2_addr;
                w_wdata = w_sum;
                w_re_en = w_accept;
                w_raddr = bin_num[ADDR_W-1:0];
            end
            default: begin
                w_we    = r_s2_valid;
                w_waddr = r_s2_addr;
                w_wdata = w_sum;
            end
        endcase
    end

    // Integration RAM: one write and one registered read per cycle, no reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        if (w_re_en) begin
            r_ram_q <= r_mem[w_raddr];
        end
    end

    // Clear sweep address, drain timer and frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_addr  <= {ADDR_W{1'b0}};
            r_drain_cnt <= 1'b0;
            r_frame_cnt <= {FCNT_W{1'b0}};
        end else begin
            r_clr_addr  <= (r_state == ST_CLEAR) ? r_clr_addr + ADDR_W'(1) : {ADDR_W{1'b0}};
            r_drain_cnt <= (r_state == ST_DRAIN) ? ~r_drain_cnt : 1'b0;
            if (w_dump_done) begin
                r_frame_cnt <= {FCNT_W{1'b0}};
            end else if (w_last_bin_acc) begin
                r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            end
        end
    end

    // Read-modify-write pipeline stages and last-write record for forwarding
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= {ADDR_W{1'b0}};
            r_s1_re    <= {DATA_W{1'b0}};
            r_s1_im    <= {DATA_W{1'b0}};
            r_s2_valid <= 1'b0;
            r_s2_addr  <= {ADDR_W{1'b0}};
            r_s2_pow   <= {ACC_W{1'b0}};
            r_s2_old   <= {ACC_W{1'b0}};
            r_wb_valid <= 1'b0;
            r_wb_addr  <= {ADDR_W{1'b0}};
            r_wb_data  <= {ACC_W{1'b0}};
        end else begin
            r_s1_valid <= w_accept;
            r_s1_addr  <= bin_num[ADDR_W-1:0];
            r_s1_re    <= fft_re;
            r_s1_im    <= fft_im;
            r_s2_valid <= r_s1_valid;
            r_s2_addr  <= r_s1_addr;
            r_s2_pow   <= ACC_W'(w_pow);
            r_s2_old   <= w_old_s1;
            r_wb_valid <= r_s2_valid;
            r_wb_addr  <= r_s2_addr;
            r_wb_data  <= w_sum;
        end
    end

    // Dump read sequencer and RAM-output stage tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_addr  <= {ADDR_W{1'b0}};
            r_rd_more  <= 1'b0;
            r_dq_valid <= 1'b0;
            r_dq_addr  <= {ADDR_W{1'b0}};
        end else begin
            if (w_drain_done) begin
                r_rd_addr <= {ADDR_W{1'b0}};
                r_rd_more <= 1'b1;
            end else if (w_rd_issue) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
                r_rd_more <= (r_rd_addr != ADDR_W'(NUM_BINS - 1));
            end
            r_dq_valid <= w_rd_issue || (r_dq_valid && !w_out_load);
            if (w_rd_issue) begin
                r_dq_addr <= r_rd_addr;
            end
        end
    end

    // Output beat register: held stable while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_bin   <= {BIN_W{1'b0}};
            r_out_data  <= {ACC_W{1'b0}};
            r_out_last  <= 1'b0;
        end else if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_out_bin   <= BIN_W'(r_dq_addr);
            r_out_data  <= r_ram_q;
            r_out_last  <= (r_dq_addr == ADDR_W'(NUM_BINS - 1));
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Drop pulse and sticky saturation flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_drop <= fft_valid && !w_accept;
            if (w_dump_done) begin
                r_sat <= 1'b0;
            end else if (r_s2_valid && w_sat) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_bin    = r_out_bin;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign drop_pulse = r_drop;
    assign sat_flag   = r_sat;

endmodule

// File: tb/tb_bin_power_accumulator.sv
// Randomized bench for bin_power_accumulator: two instances (ACC_W=48 and 33)
// share all stimulus; a spectrum-level model predicts drops and dump beats.
module tb_bin_power_accumulator;

    localparam int NB  = 8;
    localparam int NF  = 2;
    localparam int DW  = 16;
    localparam int AW  = 48;
    localparam int AWS = 33;
    localparam int BW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 fft_valid;
    logic [BW-1:0]        bin_num;
    logic signed [DW-1:0] fft_re;
    logic signed [DW-1:0] fft_im;
    logic                 out_ready;

    logic            ova, ola, dra, saa;
    logic [BW-1:0]   oba;
    logic [AW-1:0]   oda;
    logic            ovb, olb, drb, sab;
    logic [BW-1:0]   obb;
    logic [AWS-1:0]  odb;

    bin_power_accumulator #(.NUM_BINS(NB), .DATA_W(DW), .ACC_W(AW), .NUM_FRAMES(NF), .BIN_W(BW)) u_dut48 (
        .clk(clk), .reset(reset), .fft_valid(fft_valid), .bin_num(bin_num), .fft_re(fft_re), .fft_im(fft_im),
        .out_valid(ova), .out_ready(out_ready), .out_bin(oba), .out_data(oda), .out_last(ola),
        .drop_pulse(dra), .sat_flag(saa));

    bin_power_accumulator #(.NUM_BINS(NB), .DATA_W(DW), .ACC_W(AWS), .NUM_FRAMES(NF), .BIN_W(BW)) u_dut33 (
        .clk(clk), .reset(reset), .fft_valid(fft_valid), .bin_num(bin_num), .fft_re(fft_re), .fft_im(fft_im),
        .out_valid(ovb), .out_ready(out_ready), .out_bin(obb), .out_data(odb), .out_last(olb),
        .drop_pulse(drb), .sat_flag(sab));

    // Model state
    logic [63:0] acc48 [NB];
    logic [63:0] acc33 [NB];
    logic [63:0] dmp48 [NB];
    logic [63:0] dmp33 [NB];
    bit          sat48, sat33, dsat48, dsat33;
    int          phase;       // 0 clearing, 1 integrating, 2 waiting for dump to finish
    int          clear_cnt, frames, exp_bin, dumps_done;
    bit          started, exp_drop, rst_chk, stall_pend;
    logic [BW-1:0] st_bin;
    logic [63:0] st_d48, st_d33;
    int          n_vec, n_err;
    int          rmode;       // 0 ready high, 1 random, 2 ready low

    // Model scratch
    int          ph0, b;
    bit          acc_ok;
    logic [63:0] p, nv;

    function automatic logic [63:0] pow_f(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
        longint r, i;
        r = re;
        i = im;
        return 64'(r * r + i * i);
    endfunction

    function automatic logic [63:0] max_of(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Ready driver
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Compare process and model update, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            if (rst_chk) begin
                chk("rst_valid", 64'(ova), 64'd0);
                chk("rst_bin", 64'(oba), 64'd0);
                chk("rst_data", 64'(oda), 64'd0);
                chk("rst_last", 64'(ola), 64'd0);
                chk("rst_drop", 64'(dra), 64'd0);
                chk("rst_sat", 64'(saa), 64'd0);
                chk("rst_valid33", 64'(ovb), 64'd0);
                chk("rst_sat33", 64'(sab), 64'd0);
            end else begin
                chk("drop48", 64'(dra), 64'(exp_drop));
                chk("drop33", 64'(drb), 64'(exp_drop));
                if (stall_pend) begin
                    chk("stall_valid", 64'(ova), 64'd1);
                    chk("stall_bin", 64'(oba), 64'(st_bin));
                    chk("stall_data", 64'(oda), st_d48);
                    chk("stall_data33", 64'(odb), st_d33);
                end
                if (phase != 2) begin
                    chk("idle_valid", 64'(ova), 64'd0);
                    chk("idle_valid33", 64'(ovb), 64'd0);
                end else if (ova) begin
                    chk("dump_sat48", 64'(saa), 64'(dsat48));
                    chk("dump_sat33", 64'(sab), 64'(dsat33));
                end
            end
        end

        stall_pend = 1'b0;
        exp_drop   = 1'b0;
        rst_chk    = 1'b0;
        if (reset) begin
            started   = 1'b1;
            rst_chk   = 1'b1;
            phase     = 0;
            clear_cnt = NB;
            frames    = 0;
            sat48     = 1'b0;
            sat33     = 1'b0;
            for (int i = 0; i < NB; i++) begin
                acc48[i] = 64'd0;
                acc33[i] = 64'd0;
            end
        end else if (started) begin
            ph0    = phase;
            acc_ok = fft_valid && (ph0 == 1) && (bin_num < NB);
            exp_drop = fft_valid && !acc_ok;
            if (acc_ok) begin
                b  = int'(bin_num);
                p  = pow_f(fft_re, fft_im);
                nv = acc48[b] + p;
                if (nv > max_of(AW)) begin nv = max_of(AW); sat48 = 1'b1; end
                acc48[b] = nv;
                nv = acc33[b] + p;
                if (nv > max_of(AWS)) begin nv = max_of(AWS); sat33 = 1'b1; end
                acc33[b] = nv;
                if (b == NB - 1) begin
                    frames++;
                    if (frames == NF) begin
                        for (int i = 0; i < NB; i++) begin
                            dmp48[i] = acc48[i];
                            dmp33[i] = acc33[i];
                            acc48[i] = 64'd0;
                            acc33[i] = 64'd0;
                        end
                        dsat48  = sat48;
                        dsat33  = sat33;
                        sat48   = 1'b0;
                        sat33   = 1'b0;
                        frames  = 0;
                        exp_bin = 0;
                        phase   = 2;
                    end
                end
            end
            if (ph0 == 2 && ova && out_ready) begin
                chk("beat_bin", 64'(oba), 64'(exp_bin));
                chk("beat_data", 64'(oda), dmp48[exp_bin]);
                chk("beat_last", 64'(ola), 64'(exp_bin == NB - 1));
                chk("beat_bin33", 64'(obb), 64'(exp_bin));
                chk("beat_data33", 64'(odb), dmp33[exp_bin]);
                chk("beat_last33", 64'(olb), 64'(exp_bin == NB - 1));
                if (exp_bin == NB - 1) begin
                    phase = 1;
                    dumps_done++;
                end
                exp_bin++;
            end
            if (ph0 == 2 && ova && !out_ready) begin
                stall_pend = 1'b1;
                st_bin     = oba;
                st_d48     = 64'(oda);
                st_d33     = 64'(odb);
            end
            if (ph0 == 0) begin
                clear_cnt--;
                if (clear_cnt == 0) phase = 1;
            end
        end
    end

    task automatic drive(input bit v, input int bn, input int re, input int im);
        @(posedge clk);
        #1;
        fft_valid = v;
        bin_num   = BW'(bn);
        fft_re    = DW'(re);
        fft_im    = DW'(im);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        fft_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic frames_const(input int re, input int im);
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < NB; k++) drive(1'b1, k, re, im);
        drive(1'b0, 0, 0, 0);
    endtask

    task automatic frames_rand();
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < NB; k++) drive(1'b1, k, int'($urandom), int'($urandom));
        drive(1'b0, 0, 0, 0);
    endtask

    task automatic wait_dump(input int budget, input bit noisy);
        int start;
        start = dumps_done;
        for (int i = 0; i < budget; i++) begin
            if (dumps_done != start) break;
            if (noisy) drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 9)), int'($urandom), int'($urandom));
            else drive(1'b0, 0, 0, 0);
        end
        if (dumps_done == start) begin
            n_vec++;
            n_err++;
            $display("FAIL dump_timeout actual=%0d required=%0d", dumps_done, start + 1);
        end
        idle(2);
    endtask

    initial begin
        n_vec = 0; n_err = 0; dumps_done = 0; started = 1'b0;
        rmode = 0; phase = 0;
        reset = 1'b1; fft_valid = 1'b0; bin_num = '0; fft_re = '0; fft_im = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(NB + 2);

        // Model pins
        chk("model_pow_max", pow_f(-16'sd32768, -16'sd32768), 64'd2147483648);
        chk("model_pow_34", pow_f(16'sd3, -16'sd4), 64'd25);

        // Ramp: out = 2*bin^2
        frames_const(0, 0);
        wait_dump(100, 1'b0);
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < NB; k++) drive(1'b1, k, k, 0);
        drive(1'b0, 0, 0, 0);
        wait_dump(100, 1'b0);
        chk("model_ramp7", dmp48[7], 64'd98);
        chk("model_ramp3", dmp48[3], 64'd18);

        // Most negative inputs: exact power, no saturation
        frames_const(-32768, -32768);
        wait_dump(100, 1'b0);
        chk("model_maxin", dmp48[0], 64'd4294967296);
        chk("model_maxin_sat", 64'(dsat48), 64'd0);

        // Back-to-back same bin hazard
        for (int i = 0; i < 4; i++) drive(1'b1, 3, 1, 1);
        frames_const(0, 0);
        wait_dump(100, 1'b0);
        chk("model_hazard", dmp48[3], 64'd8);

        // Out-of-range bins interleaved
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < NB; k++) begin
                drive(1'b1, k, 1, 2);
                if (k == 3) drive(1'b1, 9, 100, 0);
                if (k == 5) drive(1'b1, -1, 7, 7);
            end
        drive(1'b0, 0, 0, 0);
        wait_dump(100, 1'b0);
        chk("model_oor", dmp48[0], 64'd10);

        // Stalled then randomly throttled dump, with samples sent during it
        rmode = 2;
        frames_rand();
        for (int i = 0; i < 9; i++) drive(1'b1, int'($urandom_range(0, 9)), int'($urandom), int'($urandom));
        rmode = 1;
        wait_dump(300, 1'b1);
        rmode = 0;
        frames_const(0, 0);
        wait_dump(100, 1'b0);
        chk("model_noleak", dmp48[6], 64'd0);

        // Random traffic with hazards and out-of-range bins, starting during CLEAR
        do_reset();
        for (int r = 0; r < 3; r++) begin
            rmode = (r == 1) ? 1 : 0;
            for (int k = 0; k < 3000 && phase != 2; k++)
                drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 9)), int'($urandom), int'($urandom));
            wait_dump(300, 1'b1);
        end
        rmode = 0;

        // Reset mid-accumulation discards partial sums
        for (int i = 0; i < 5; i++) drive(1'b1, i, 1000, 1000);
        do_reset();
        idle(NB + 2);
        frames_const(1, 0);
        wait_dump(100, 1'b0);
        chk("model_rst", dmp48[4], 64'd2);

        // Saturation of the narrow accumulator
        for (int i = 0; i < 6; i++) drive(1'b1, 5, -32768, -32768);
        frames_const(-32768, -32768);
        wait_dump(100, 1'b0);
        chk("model_sat33", dmp33[5], 64'd8589934591);
        chk("model_sat33_flag", 64'(dsat33), 64'd1);
        chk("model_sat48_flag", 64'(dsat48), 64'd0);

        // Sticky flag cleared for the next integration
        frames_const(0, 0);
        wait_dump(100, 1'b0);
        chk("model_satclr", 64'(dsat33), 64'd0);

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
